qpsk_demod: RTL and testbench
=============================

QPSK_DEMOD -- requirements
Module: qpsk_demod

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning the signed width of each I/Q sample.
REQ-002 The block SHALL have parameter TH, default 16'd1, meaning the low-confidence magnitude threshold, unsigned, compared against |sample|.
REQ-003 The block SHALL have the following ports; there is one clock, and reset is synchronous and active-high:
  clk        in   1    clock, all state updates on posedge
  reset      in   1    synchronous active-high reset
  in_en      in   1    input symbol valid
  inx        in   W    signed in-phase sample
  iny        in   W    signed quadrature sample
  in_ready   out  1    block can accept a symbol this cycle
  out        out  1    serial hard-decision bit
  out_en     out  1    out is valid this cycle
  out_ready  in   1    downstream consumes out this cycle
  low_conf   out  1    current symbol had |inx|<TH or |iny|<TH
  sym_cnt    out  16   count of accepted symbols

Function
REQ-004 A symbol SHALL be accepted on any posedge where in_en=1 and in_ready=1; with in_en=1 and in_ready=0, inx/iny SHALL be ignored.
REQ-005 The decision SHALL map the accepted sample as follows, with zero counted as non-negative: inx>=0,iny>=0 -> 2'b00; inx<0,iny>=0 -> 2'b01; inx<0,iny<0 -> 2'b10; inx>=0,iny<0 -> 2'b11.
REQ-006 The decision bits SHALL be registered at acceptance and be the exact inverse of the transmit mapper's (+1,+1)/(-1,+1)/(-1,-1)/(+1,-1) constellation.
REQ-007 The FSM SHALL have three states: IDLE, SEND_MSB and SEND_LSB.
REQ-008 IDLE -> SEND_MSB SHALL occur on acceptance.
REQ-009 SEND_MSB -> SEND_LSB SHALL occur when out_ready=1; otherwise the FSM SHALL hold in SEND_MSB.
REQ-010 In SEND_LSB with out_ready=1, the FSM SHALL go to SEND_MSB if a new symbol is accepted in the same cycle, else to IDLE; with out_ready=0 it SHALL hold.
REQ-011 out_en SHALL be 1 exactly in SEND_MSB and SEND_LSB; out SHALL be decision[1] in SEND_MSB and decision[0] in SEND_LSB (MSB-first, matching transmit bit order).
REQ-012 in_ready SHALL be 1 in IDLE and in SEND_LSB when out_ready=1, and 0 otherwise; this is the only combinational input-to-output path.
REQ-013 Latency SHALL be one cycle from acceptance to the first out_en cycle; sustained throughput SHALL be one symbol per 2 cycles with out_ready held at 1, with no bubble.
REQ-014 out, decision and low_conf SHALL hold stable while out_en=1 and out_ready=0.
REQ-015 low_conf SHALL be registered at acceptance and be valid for both bits of that symbol.
REQ-016 Magnitude SHALL saturate: |-2^(W-1)| is taken as 2^(W-1)-1.
REQ-017 With TH=0, low_conf SHALL never assert.
REQ-018 sym_cnt SHALL increment by 1 on each acceptance and wrap from 16'hFFFF to 0.
REQ-019 out_ready SHALL be ignored in IDLE.

Reset
REQ-020 While reset=1 at a posedge, the FSM SHALL go to IDLE, and decision, out, out_en, low_conf and sym_cnt SHALL be cleared to 0.
REQ-021 Reset SHALL have priority over acceptance in the same cycle; the symbol SHALL be dropped and sym_cnt SHALL stay at 0.
REQ-022 Reset asserted in SEND_MSB or SEND_LSB SHALL abort the symbol, with no remaining bit emitted after release.
REQ-023 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-024 Bench: out_ready=1, feed (inx,iny)=(100,100),(-100,100),(-100,-100),(100,-100) back-to-back -> bit stream 0,0,0,1,1,0,1,1 on consecutive out_en cycles; sym_cnt=4.
REQ-025 Bench: inx=0, iny=-1 -> bits 1,1; inx=-32768, iny=32767 -> bits 0,1 with low_conf=0 at TH=1.
REQ-026 Bench: TH=50, (inx,iny)=(10,-200) -> bits 1,1 with low_conf=1 on both out_en cycles.
REQ-027 Bench: hold out_ready=0 for 5 cycles during SEND_MSB -> out/out_en stable, in_ready=0, new in_en ignored; release -> remaining bits emitted in order.
REQ-028 Bench: assert reset during SEND_LSB -> next cycle out_en=0, sym_cnt=0, in_ready=1; a reset coincident with in_en=1 -> no symbol emitted.
REQ-029 Bench: preload sym_cnt to 16'hFFFF via 65535 symbols (or force) and accept one more -> sym_cnt=0.

Source files
------------

// File: rtl/qpsk_demod.sv
// qpsk_demod: hard-decision QPSK slicer with a serial bit output.
//
// Each accepted (inx, iny) sample is sliced to a 2-bit symbol. The symbol is
// emitted MSB first, one bit per out_ready handshake. A low-confidence flag
// marks symbols where either rail magnitude is below TH.
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset
//   in_en      input symbol valid
//   inx, iny   signed I/Q sample, W bits each
//   in_ready   block can accept a symbol this cycle (combinational on out_ready)
//   out        serial hard-decision bit
//   out_en     out is valid this cycle
//   out_ready  downstream consumes out this cycle
//   low_conf   current symbol had |inx| < TH or |iny| < TH
//   sym_cnt    count of accepted symbols, wraps at 16 bits
module qpsk_demod #(
    parameter int unsigned  W  = 16,
    parameter logic [W-1:0] TH = 16'd1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_en,
    input  logic signed [W-1:0] inx,
    input  logic signed [W-1:0] iny,
    output logic                in_ready,
    output logic                out,
    output logic                out_en,
    input  logic                out_ready,
    output logic                low_conf,
    output logic [15:0]         sym_cnt
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND_MSB = 2'd1;
    localparam logic [1:0] SEND_LSB = 2'd2;

    // Saturating magnitude: the most negative code has no positive
    // counterpart, so it maps to the largest positive value.
    function automatic logic [W-1:0] sat_abs(input logic signed [W-1:0] x);
        logic signed [W-1:0] most_neg;
        most_neg = {1'b1, {(W-1){1'b0}}};
        if (x == most_neg) begin
            return {1'b0, {(W-1){1'b1}}};
        end else if (x[W-1]) begin
            return $unsigned(-x);
        end else begin
            return $unsigned(x);
        end
    endfunction

    // Inverse of the (+1,+1)/(-1,+1)/(-1,-1)/(+1,-1) -> 00/01/10/11 mapper.
    // Zero counts as non-negative, so only the sign bits matter.
    function automatic logic [1:0] slice_sym(input logic signed [W-1:0] x,
                                              input logic signed [W-1:0] y);
        return {y[W-1], x[W-1] ^ y[W-1]};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  dec_q, dec_d;
    logic        lc_q, lc_d;
    logic [15:0] sym_cnt_q, sym_cnt_d;
    logic        accept;

    // in_ready is the only path from an input (out_ready) to an output:
    // the last bit leaving in SEND_LSB frees the decision register that cycle.
    assign in_ready = (state_q == IDLE) || ((state_q == SEND_LSB) && out_ready);
    assign accept   = in_en && in_ready;

    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        lc_d      = lc_q;
        sym_cnt_d = sym_cnt_q;

        if (accept) begin
            dec_d     = slice_sym(inx, iny);
            lc_d      = (sat_abs(inx) < TH) || (sat_abs(iny) < TH);
            sym_cnt_d = sym_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = SEND_MSB;
            end
            SEND_MSB: begin
                if (out_ready) state_d = SEND_LSB;
            end
            SEND_LSB: begin
                if (out_ready) state_d = accept ? SEND_MSB : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dec_q     <= 2'b00;
            lc_q      <= 1'b0;
            sym_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            lc_q      <= lc_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

    assign out_en   = (state_q == SEND_MSB) || (state_q == SEND_LSB);
    assign out      = (state_q == SEND_MSB) ? dec_q[1] :
                      (state_q == SEND_LSB) ? dec_q[0] : 1'b0;
    assign low_conf = lc_q;
    assign sym_cnt  = sym_cnt_q;

endmodule

// File: tb/tb_qpsk_demod.sv
// Directed testbench for qpsk_demod. Three instances share stimulus:
// TH=1 (main), TH=50 and TH=0; the latter two are used for low_conf checks.
module tb_qpsk_demod;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_en;
    logic signed [15:0] inx, iny;
    logic               out_ready;

    logic               in_ready, out_w, out_en, low_conf;
    logic [15:0]        sym_cnt;
    logic               in_ready50, out50, out_en50, low_conf50;
    logic [15:0]        sym_cnt50;
    logic               in_ready0, out0, out_en0, low_conf0;
    logic [15:0]        sym_cnt0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    qpsk_demod #(.W(16), .TH(16'd1)) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .inx(inx), .iny(iny),
        .in_ready(in_ready), .out(out_w), .out_en(out_en), .out_ready(out_ready),
        .low_conf(low_conf), .sym_cnt(sym_cnt)
    );

    qpsk_demod #(.W(16), .TH(16'd50)) dut50 (
        .clk(clk), .reset(reset), .in_en(in_en), .inx(inx), .iny(iny),
        .in_ready(in_ready50), .out(out50), .out_en(out_en50), .out_ready(out_ready),
        .low_conf(low_conf50), .sym_cnt(sym_cnt50)
    );

    qpsk_demod #(.W(16), .TH(16'd0)) dut0 (
        .clk(clk), .reset(reset), .in_en(in_en), .inx(inx), .iny(iny),
        .in_ready(in_ready0), .out(out0), .out_en(out_en0), .out_ready(out_ready),
        .low_conf(low_conf0), .sym_cnt(sym_cnt0)
    );

    typedef struct {
        logic               rst, en, ordy;
        logic signed [15:0] x, y;
        logic               chk;
        logic               e_oen, e_out, e_rdy, e_lc, e_lc50;
        logic [15:0]        e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic en, logic ordy,
                                logic signed [15:0] x, logic signed [15:0] y,
                                logic chk, logic oen, logic o, logic rdy,
                                logic lc, logic lc50, logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.ordy = ordy; v.x = x; v.y = y; v.chk = chk;
        v.e_oen = oen; v.e_out = o; v.e_rdy = rdy; v.e_lc = lc; v.e_lc50 = lc50;
        v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply inputs away from the posedge, then let combinational outputs settle.
    task automatic step(input logic rst, input logic en, input logic ordy,
                        input logic signed [15:0] x, input logic signed [15:0] y);
        @(negedge clk);
        reset = rst; in_en = en; out_ready = ordy; inx = x; iny = y;
        #1;
    endtask

    initial begin
        reset = 1'b1; in_en = 1'b0; out_ready = 1'b1; inx = '0; iny = '0;

        //                rst en ordy  x       y     chk oen o rdy lc lc50 cnt
        vecs.push_back(mk(1, 0, 1,    0,      0,    0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  0, 0, 1, 0, 0, 0));
        // four constellation points back to back
        vecs.push_back(mk(0, 1, 1,    100,    100,  1,  0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1,    -100,   100,  1,  1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  1, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 1,    -100,   -100, 1,  1, 1, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  1, 1, 0, 0, 0, 3));
        vecs.push_back(mk(0, 1, 1,    100,    -100, 1,  1, 0, 1, 0, 0, 3));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  1, 1, 0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  1, 1, 1, 0, 0, 4));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  0, 0, 1, 0, 0, 4));
        // zero is non-negative; |0| < 1 gives low confidence
        vecs.push_back(mk(0, 1, 1,    0,      -1,   1,  0, 0, 1, 0, 0, 4));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  1, 1, 0, 1, 1, 5));
        // most negative sample saturates to 32767, not low confidence
        vecs.push_back(mk(0, 1, 1,    16'sh8000, 16'sh7FFF, 1, 1, 1, 1, 1, 1, 5));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  1, 0, 0, 0, 0, 6));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  1, 1, 1, 0, 0, 6));
        // small I rail is low confidence only at TH=50
        vecs.push_back(mk(0, 1, 1,    10,     -200, 1,  0, 0, 1, 0, 0, 6));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  1, 1, 0, 0, 1, 7));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  1, 1, 1, 0, 1, 7));
        vecs.push_back(mk(0, 0, 1,    0,      0,    1,  0, 0, 1, 0, 1, 7));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].ordy, vecs[i].x, vecs[i].y);
            if (vecs[i].chk) begin
                chk($sformatf("v%0d out_en", i), {15'd0, out_en}, {15'd0, vecs[i].e_oen});
                if (vecs[i].e_oen)
                    chk($sformatf("v%0d out", i), {15'd0, out_w}, {15'd0, vecs[i].e_out});
                chk($sformatf("v%0d in_ready", i), {15'd0, in_ready}, {15'd0, vecs[i].e_rdy});
                chk($sformatf("v%0d low_conf", i), {15'd0, low_conf}, {15'd0, vecs[i].e_lc});
                chk($sformatf("v%0d low_conf_th50", i), {15'd0, low_conf50}, {15'd0, vecs[i].e_lc50});
                chk($sformatf("v%0d low_conf_th0", i), {15'd0, low_conf0}, 16'd0);
                chk($sformatf("v%0d sym_cnt", i), sym_cnt, vecs[i].e_cnt);
            end
        end

        // Stall in SEND_MSB: out_ready ignored in IDLE, then held low for 5 cycles.
        step(0, 1, 0, -5, 7);
        chk("stall accept_in_idle in_ready", {15'd0, in_ready}, 16'd1);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 50, 50);
            chk($sformatf("stall%0d out_en", k), {15'd0, out_en}, 16'd1);
            chk($sformatf("stall%0d out", k), {15'd0, out_w}, 16'd0);
            chk($sformatf("stall%0d in_ready", k), {15'd0, in_ready}, 16'd0);
            chk($sformatf("stall%0d low_conf_th50", k), {15'd0, low_conf50}, 16'd1);
            chk($sformatf("stall%0d sym_cnt", k), sym_cnt, 16'd8);
        end
        step(0, 0, 1, 0, 0);
        chk("release msb out_en", {15'd0, out_en}, 16'd1);
        chk("release msb out", {15'd0, out_w}, 16'd0);
        step(0, 0, 0, 0, 0);
        chk("lsb hold out_en", {15'd0, out_en}, 16'd1);
        chk("lsb hold out", {15'd0, out_w}, 16'd1);
        chk("lsb hold in_ready", {15'd0, in_ready}, 16'd0);
        step(0, 0, 1, 0, 0);
        chk("release lsb out", {15'd0, out_w}, 16'd1);
        chk("release lsb in_ready", {15'd0, in_ready}, 16'd1);
        step(0, 0, 1, 0, 0);
        chk("stall done out_en", {15'd0, out_en}, 16'd0);
        chk("stall done sym_cnt", sym_cnt, 16'd8);

        // Reset during SEND_LSB aborts the symbol.
        step(0, 1, 1, 1, 1);
        step(0, 0, 1, 0, 0);
        chk("rst msb sym_cnt", sym_cnt, 16'd9);
        step(1, 0, 1, 0, 0);
        chk("rst in lsb out_en", {15'd0, out_en}, 16'd1);
        step(0, 0, 1, 0, 0);
        chk("after rst out_en", {15'd0, out_en}, 16'd0);
        chk("after rst out", {15'd0, out_w}, 16'd0);
        chk("after rst sym_cnt", sym_cnt, 16'd0);
        chk("after rst in_ready", {15'd0, in_ready}, 16'd1);
        step(0, 0, 1, 0, 0);
        chk("after rst no bit", {15'd0, out_en}, 16'd0);

        // Reset coincident with in_en drops the symbol.
        step(1, 1, 1, -3, -3);
        step(0, 0, 1, 0, 0);
        chk("rst+en out_en", {15'd0, out_en}, 16'd0);
        chk("rst+en sym_cnt", sym_cnt, 16'd0);
        step(0, 0, 1, 0, 0);
        chk("rst+en later out_en", {15'd0, out_en}, 16'd0);
        chk("rst+en later sym_cnt", sym_cnt, 16'd0);

        // Counter wrap from 16'hFFFF.
        @(negedge clk);
        in_en = 1'b0;
        force dut.sym_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.sym_cnt_q;
        #1;
        chk("wrap preload sym_cnt", sym_cnt, 16'hFFFF);
        step(0, 1, 1, 7, 7);
        chk("wrap accept in_ready", {15'd0, in_ready}, 16'd1);
        step(0, 0, 1, 0, 0);
        chk("wrap sym_cnt", sym_cnt, 16'd0);
        chk("wrap out_en", {15'd0, out_en}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
